// File: rtl/dp_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin datapath arbiter.
// The defaults match the bit widths of the attached datapath.
package dp_arb_pkg;

    localparam int NREQ_DEF    = 4;
    localparam int DW_DEF      = 9;
    localparam int RW_DEF      = 18;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Index width for a count of n items; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/dp_rr_arbiter_if.sv
// Client and datapath handshake bundle for dp_rr_arbiter.
// The arbiter uses the master view; clients and the datapath use the slave view.
interface dp_rr_arbiter_if
    import dp_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int DW   = DW_DEF,
    parameter int RW   = RW_DEF
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    rsp_valid;
    logic [RW-1:0]      rsp_data;
    logic               rsp_err;
    logic               dp_start;
    logic [DW-1:0]      dp_a;
    logic [DW-1:0]      dp_b;
    logic               dp_done;
    logic [RW-1:0]      dp_result;
    logic               busy;

    modport master (
        input  req, req_a, req_b, dp_done, dp_result,
        output gnt, rsp_valid, rsp_data, rsp_err, dp_start, dp_a, dp_b, busy
    );

    modport slave (
        output req, req_a, req_b, dp_done, dp_result,
        input  gnt, rsp_valid, rsp_data, rsp_err, dp_start, dp_a, dp_b, busy
    );

endinterface

// File: rtl/dp_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: the lowest requester above last_grant wins,
// otherwise the lowest requester overall (wrap-around).
module rr_pick
    import dp_arb_pkg::*;
#(
    parameter  int NREQ = NREQ_DEF,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [NREQ-1:0] upper_mask;
    logic [NREQ-1:0] masked;
    logic [NREQ-1:0] src;
    logic            found;

    always_comb begin
        upper_mask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            upper_mask[i] = (i > 32'(last_grant));
        end
        masked = req & upper_mask;
        src    = (masked != '0) ? masked : req;

        pick  = '0;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (src[i] && !found) begin
                found   = 1'b1;
                pick[i] = 1'b1;
                idx     = IW'(i);
            end
        end
        any = |req;
    end

endmodule

// File: rtl/dp_rr_arbiter.sv
// Round-robin arbiter sharing one start/done datapath among NREQ requesters,
// with a WAIT timeout that returns an error response instead of hanging.
module dp_rr_arbiter
    import dp_arb_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int DW      = DW_DEF,
    parameter int RW      = RW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    dp_rr_arbiter_if.master   bus
);

    localparam int IW = idx_w(NREQ);
    localparam int CW = idx_w(TIMEOUT);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT - 1);

    state_t          state, state_nx;
    logic [IW-1:0]   owner, owner_nx;
    logic [NREQ-1:0] owner_oh, owner_oh_nx;
    logic [IW-1:0]   last_grant, last_grant_nx;
    logic [CW-1:0]   cnt, cnt_nx;

    logic [NREQ-1:0] gnt_q, gnt_nx;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_nx;
    logic [RW-1:0]   rsp_data_q, rsp_data_nx;
    logic            rsp_err_q, rsp_err_nx;
    logic            dp_start_q, dp_start_nx;
    logic [DW-1:0]   dp_a_q, dp_a_nx;
    logic [DW-1:0]   dp_b_q, dp_b_nx;
    logic            busy_q, busy_nx;

    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [DW-1:0]   a_sel, b_sel;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req        (bus.req),
        .last_grant (last_grant),
        .pick       (pick),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    // Operand mux driven by the one-hot pick
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (pick[i]) begin
                a_sel = bus.req_a[i*DW +: DW];
                b_sel = bus.req_b[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_nx      = state;
        owner_nx      = owner;
        owner_oh_nx   = owner_oh;
        last_grant_nx = last_grant;
        cnt_nx        = cnt;
        gnt_nx        = '0;
        dp_start_nx   = 1'b0;
        rsp_valid_nx  = '0;
        rsp_data_nx   = rsp_data_q;
        rsp_err_nx    = rsp_err_q;
        dp_a_nx       = dp_a_q;
        dp_b_nx       = dp_b_q;

        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    owner_nx    = pick_idx;
                    owner_oh_nx = pick;
                    dp_a_nx     = a_sel;
                    dp_b_nx     = b_sel;
                    gnt_nx      = pick;
                    dp_start_nx = 1'b1;
                    state_nx    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_nx   = '0;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                // done on the limit cycle still counts as a normal completion
                if (bus.dp_done) begin
                    rsp_data_nx  = bus.dp_result;
                    rsp_err_nx   = 1'b0;
                    rsp_valid_nx = owner_oh;
                    state_nx     = ST_RESP;
                end else if (cnt == CNT_LIMIT) begin
                    rsp_data_nx  = '0;
                    rsp_err_nx   = 1'b1;
                    rsp_valid_nx = owner_oh;
                    state_nx     = ST_RESP;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ST_RESP: begin
                last_grant_nx = owner;
                state_nx      = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase

        busy_nx = (state_nx != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            owner       <= '0;
            owner_oh    <= '0;
            last_grant  <= IW'(NREQ - 1);
            cnt         <= '0;
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            dp_start_q  <= 1'b0;
            dp_a_q      <= '0;
            dp_b_q      <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            owner_oh    <= owner_oh_nx;
            last_grant  <= last_grant_nx;
            cnt         <= cnt_nx;
            gnt_q       <= gnt_nx;
            rsp_valid_q <= rsp_valid_nx;
            rsp_data_q  <= rsp_data_nx;
            rsp_err_q   <= rsp_err_nx;
            dp_start_q  <= dp_start_nx;
            dp_a_q      <= dp_a_nx;
            dp_b_q      <= dp_b_nx;
            busy_q      <= busy_nx;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.dp_start  = dp_start_q;
    assign bus.dp_a      = dp_a_q;
    assign bus.dp_b      = dp_b_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dp_rr_arbiter.sv
// Bench for dp_rr_arbiter: a behavioural datapath with random done latency,
// a modular-arithmetic round-robin model and cycle-stamped grant/response logs.
module tb_dp_rr_arbiter;
    import dp_arb_pkg::*;

    localparam int NREQ    = 4;
    localparam int DW      = DW_DEF;
    localparam int RW      = RW_DEF;
    localparam int TIMEOUT = TIMEOUT_DEF;
    localparam int NEVER   = 1000;
    localparam int OW      = 2*NREQ + RW + 2 + 2*DW + 1;

    typedef struct {
        int              c;
        int              d;
        logic            st;
        logic [NREQ-1:0] v;
        logic [NREQ-1:0] seen;
        logic [DW-1:0]   a;
        logic [DW-1:0]   b;
    } gnt_rec_t;

    typedef struct {
        int              c;
        logic [NREQ-1:0] v;
        logic [RW-1:0]   data;
        logic            err;
    } rsp_rec_t;

    logic            clk    = 1'b0;
    logic            rst_n  = 1'b0;
    logic [NREQ-1:0] req    = '0;
    logic [DW-1:0]   opa [NREQ];
    logic [DW-1:0]   opb [NREQ];
    logic            m_done = 1'b0;
    logic            f_done = 1'b0;
    logic [RW-1:0]   dp_res = '0;
    logic [DW-1:0]   lat_a  = '0;
    logic [DW-1:0]   lat_b  = '0;
    logic            auto_drop = 1'b1;
    int tests = 0, fails = 0, cyc = 0, rem = 0;
    int d_lo = 1, d_hi = 1, m_last = NREQ - 1;
    gnt_rec_t gq[$];
    rsp_rec_t rq[$];

    always #5 clk = ~clk;

    dp_rr_arbiter_if #(.NREQ(NREQ), .DW(DW), .RW(RW)) bus ();

    dp_rr_arbiter #(.NREQ(NREQ), .DW(DW), .RW(RW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    assign bus.req       = req;
    assign bus.dp_done   = m_done | f_done;
    assign bus.dp_result = dp_res;
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_ops
        assign bus.req_a[gi*DW +: DW] = opa[gi];
        assign bus.req_b[gi*DW +: DW] = opb[gi];
    end

    function automatic int rr_winner(input logic [NREQ-1:0] r, input int last);
        for (int off = 1; off <= NREQ; off++)
            if (r[(last + off) % NREQ]) return (last + off) % NREQ;
        return -1;
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [OW-1:0] all_out();
        return {bus.gnt, bus.rsp_valid, bus.rsp_data, bus.rsp_err,
                bus.dp_start, bus.dp_a, bus.dp_b, bus.busy};
    endfunction

    function automatic logic [RW-1:0] prod(input int i);
        return RW'(int'(opa[i]) * int'(opb[i]));
    endfunction

    // One clock: behave as the datapath and as requesters, log DUT events.
    task automatic tick();
        logic [NREQ-1:0] seen;
        gnt_rec_t g;
        rsp_rec_t r;
        int d;
        @(posedge clk);
        #1;
        cyc++;
        seen   = req;
        m_done = 1'b0;
        dp_res = RW'($urandom);
        if (rem > 0) begin
            rem--;
            if (rem == 0) begin
                m_done = 1'b1;
                dp_res = RW'(int'(lat_a) * int'(lat_b));
            end
        end
        d = -1;
        if (bus.dp_start) begin
            d     = (d_lo >= NEVER) ? NEVER : int'($urandom_range(d_hi, d_lo));
            rem   = d;
            lat_a = bus.dp_a;
            lat_b = bus.dp_b;
        end
        if (bus.gnt != '0) begin
            g.c = cyc; g.d = d; g.st = bus.dp_start; g.v = bus.gnt;
            g.seen = seen; g.a = bus.dp_a; g.b = bus.dp_b;
            gq.push_back(g);
            if (auto_drop) req = req & ~bus.gnt;
        end
        if (bus.rsp_valid != '0) begin
            r.c = cyc; r.v = bus.rsp_valid; r.data = bus.rsp_data; r.err = bus.rsp_err;
            rq.push_back(r);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        #12;
        tests++;
        if (all_out() !== '0) begin
            fails++; $display("FAIL reset_outputs: got %h expected 0", all_out());
        end
        @(posedge clk);
        #3;
        rst_n  = 1'b1;
        m_last = NREQ - 1;
        rem    = 0;
        tick(); tick();
        tests++;
        if (all_out() !== '0) begin
            fails++; $display("FAIL idle_after_reset: got %h expected 0", all_out());
        end
    endtask

    task automatic test_single_job();
        int c0;
        gq.delete(); rq.delete();
        auto_drop = 1'b1; d_lo = 6; d_hi = 6;
        opa[0] = 9'd12; opb[0] = 9'd5;
        req = 4'b0001;
        c0  = cyc;
        repeat (12) tick();
        tests++;
        if (gq.size() != 1) begin
            fails++; $display("FAIL single_gnt_count: got %0d expected 1", gq.size());
        end else if (gq[0].c != c0 + 1 || gq[0].v !== 4'b0001 || gq[0].st !== 1'b1 ||
                     gq[0].a !== 9'd12 || gq[0].b !== 9'd5) begin
            fails++;
            $display("FAIL single_gnt: got cyc %0d gnt %b start %b a %0d b %0d expected cyc %0d gnt 0001 start 1 a 12 b 5",
                     gq[0].c - c0, gq[0].v, gq[0].st, gq[0].a, gq[0].b, 1);
        end
        tests++;
        if (rq.size() != 1) begin
            fails++; $display("FAIL single_rsp_count: got %0d expected 1", rq.size());
        end else if (rq[0].c != c0 + 8 || rq[0].v !== 4'b0001 ||
                     rq[0].data !== 18'd60 || rq[0].err !== 1'b0) begin
            fails++;
            $display("FAIL single_rsp: got cyc %0d v %b data %0d err %b expected cyc 8 v 0001 data 60 err 0",
                     rq[0].c - c0, rq[0].v, rq[0].data, rq[0].err);
        end
        tests++;
        if (bus.rsp_data !== 18'd60 || bus.rsp_err !== 1'b0 || bus.rsp_valid !== '0 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL single_hold: got data %0d err %b v %b busy %b expected 60 0 0000 0",
                     bus.rsp_data, bus.rsp_err, bus.rsp_valid, bus.busy);
        end
        m_last = 0;
    endtask

    task automatic test_round_robin();
        int budget, exp, got;
        int served [NREQ];
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = DW'($urandom); opb[i] = DW'($urandom);
        end
        gq.delete(); rq.delete();
        auto_drop = 1'b0; d_lo = 1; d_hi = 8;
        req = '1;
        budget = 0;
        while (rq.size() < 8 && budget < 200) begin tick(); budget++; end
        req = '0;
        repeat (4) tick();
        tests++;
        if (rq.size() != 8 || gq.size() != 8) begin
            fails++;
            $display("FAIL rr_job_count: got gnt %0d rsp %0d expected 8 8", gq.size(), rq.size());
        end else begin
            for (int j = 0; j < 8; j++) begin
                exp = rr_winner(gq[j].seen, m_last);
                got = oh_idx(gq[j].v);
                tests++;
                if (got != exp || exp < 0) begin
                    fails++; $display("FAIL rr_order job %0d: got %0d expected %0d", j, got, exp);
                end else begin
                    tests++;
                    if (rq[j].v !== gq[j].v || rq[j].c != gq[j].c + gq[j].d + 1 ||
                        rq[j].err !== 1'b0 || rq[j].data !== prod(exp)) begin
                        fails++;
                        $display("FAIL rr_rsp job %0d: got v %b lat %0d data %0d err %b expected v %b lat %0d data %0d err 0",
                                 j, rq[j].v, rq[j].c - gq[j].c, rq[j].data, rq[j].err,
                                 gq[j].v, gq[j].d + 1, prod(exp));
                    end
                end
                if (exp >= 0) m_last = exp;
                if (j > 0) begin
                    tests++;
                    if (gq[j].c - gq[j-1].c != gq[j-1].d + 3) begin
                        fails++;
                        $display("FAIL back_to_back job %0d: got period %0d expected %0d",
                                 j, gq[j].c - gq[j-1].c, gq[j-1].d + 3);
                    end
                end
            end
            for (int w = 0; w < 2; w++) begin
                for (int i = 0; i < NREQ; i++) served[i] = 0;
                for (int j = 4*w; j < 4*w + 4; j++)
                    if (oh_idx(gq[j].v) >= 0) served[oh_idx(gq[j].v)]++;
                for (int i = 0; i < NREQ; i++) begin
                    tests++;
                    if (served[i] != 1) begin
                        fails++;
                        $display("FAIL rr_fair window %0d req %0d: got %0d grants expected 1", w, i, served[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_priority_after();
        int budget, exp;
        int want [3];
        want[0] = 2; want[1] = 3; want[2] = 0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = DW'($urandom); opb[i] = DW'($urandom);
        end
        gq.delete(); rq.delete();
        auto_drop = 1'b1; d_lo = 4; d_hi = 6;
        req = 4'b0100;
        tick(); tick();
        req = req | 4'b1001;
        budget = 0;
        while (rq.size() < 3 && budget < 80) begin tick(); budget++; end
        repeat (3) tick();
        tests++;
        if (gq.size() != 3 || rq.size() != 3) begin
            fails++;
            $display("FAIL prio_job_count: got gnt %0d rsp %0d expected 3 3", gq.size(), rq.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                exp = rr_winner(gq[j].seen, m_last);
                tests++;
                if (oh_idx(gq[j].v) != want[j] || exp != want[j]) begin
                    fails++;
                    $display("FAIL prio_order job %0d: got %0d expected %0d", j, oh_idx(gq[j].v), want[j]);
                end
                tests++;
                if (rq[j].v !== gq[j].v || rq[j].data !== prod(want[j])) begin
                    fails++;
                    $display("FAIL prio_rsp job %0d: got v %b data %0d expected v %b data %0d",
                             j, rq[j].v, rq[j].data, gq[j].v, prod(want[j]));
                end
                m_last = want[j];
            end
        end
    endtask

    task automatic test_timeout();
        int c0;
        int dlys [3];
        logic            exp_err;
        logic [RW-1:0]   exp_data;
        dlys[0] = NEVER; dlys[1] = TIMEOUT; dlys[2] = TIMEOUT + 1;
        auto_drop = 1'b1;
        for (int k = 0; k < 3; k++) begin
            opa[1] = DW'($urandom); opb[1] = DW'($urandom);
            gq.delete(); rq.delete();
            d_lo = dlys[k]; d_hi = dlys[k];
            exp_err  = (dlys[k] > TIMEOUT);
            exp_data = exp_err ? '0 : prod(1);
            req = 4'b0010;
            c0  = cyc;
            repeat (TIMEOUT + 7) tick();
            tests++;
            if (gq.size() != 1 || rq.size() != 1) begin
                fails++;
                $display("FAIL timeout_count d=%0d: got gnt %0d rsp %0d expected 1 1", dlys[k], gq.size(), rq.size());
            end else if (rq[0].c != c0 + TIMEOUT + 2 || rq[0].v !== 4'b0010 ||
                         rq[0].err !== exp_err || rq[0].data !== exp_data) begin
                fails++;
                $display("FAIL timeout_rsp d=%0d: got cyc %0d v %b err %b data %0d expected cyc %0d v 0010 err %b data %0d",
                         dlys[k], rq[0].c - c0, rq[0].v, rq[0].err, rq[0].data,
                         TIMEOUT + 2, exp_err, exp_data);
            end
            tests++;
            if (bus.busy !== 1'b0 || bus.rsp_err !== exp_err || bus.rsp_data !== exp_data) begin
                fails++;
                $display("FAIL timeout_idle d=%0d: got busy %b err %b data %0d expected 0 %b %0d",
                         dlys[k], bus.busy, bus.rsp_err, bus.rsp_data, exp_err, exp_data);
            end
            m_last = 1;
        end
    endtask

    task automatic test_reset_mid();
        int exp;
        gq.delete(); rq.delete();
        auto_drop = 1'b1; d_lo = NEVER; d_hi = NEVER;
        req = 4'b1000;
        repeat (6) tick();
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (all_out() !== '0) begin
            fails++; $display("FAIL reset_mid_outputs: got %h expected 0", all_out());
        end
        rem = 0; req = '0; m_last = NREQ - 1;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        gq.delete(); rq.delete();
        repeat (20) tick();
        tests++;
        if (rq.size() != 0 || gq.size() != 0) begin
            fails++; $display("FAIL reset_mid_stray: got gnt %0d rsp %0d expected 0 0", gq.size(), rq.size());
        end
        d_lo = 3; d_hi = 3;
        opa[0] = DW'($urandom); opb[0] = DW'($urandom);
        opa[3] = DW'($urandom); opb[3] = DW'($urandom);
        req = 4'b1001;
        repeat (20) tick();
        tests++;
        if (gq.size() != 2) begin
            fails++; $display("FAIL reset_mid_count: got %0d grants expected 2", gq.size());
        end else begin
            exp = rr_winner(gq[0].seen, m_last);
            if (oh_idx(gq[0].v) != 0 || exp != 0 || oh_idx(gq[1].v) != 3) begin
                fails++;
                $display("FAIL reset_mid_order: got %0d,%0d expected 0,3", oh_idx(gq[0].v), oh_idx(gq[1].v));
            end
        end
        m_last = 3;
    endtask

    task automatic test_done_ignored();
        int c0;
        gq.delete(); rq.delete();
        req = '0; auto_drop = 1'b1; d_lo = 4; d_hi = 4;
        repeat (2) tick();
        f_done = 1'b1;
        tick();
        f_done = 1'b0;
        repeat (3) tick();
        tests++;
        if (bus.busy !== 1'b0 || rq.size() != 0 || gq.size() != 0) begin
            fails++;
            $display("FAIL done_in_idle: got busy %b rsp %0d gnt %0d expected 0 0 0", bus.busy, rq.size(), gq.size());
        end
        opa[2] = DW'($urandom); opb[2] = DW'($urandom);
        req = 4'b0100;
        c0  = cyc;
        tick();
        f_done = 1'b1;
        tick();
        f_done = 1'b0;
        repeat (10) tick();
        tests++;
        if (rq.size() != 1) begin
            fails++; $display("FAIL done_in_issue_count: got %0d expected 1", rq.size());
        end else if (rq[0].c != c0 + 6 || rq[0].data !== prod(2) || rq[0].err !== 1'b0 || rq[0].v !== 4'b0100) begin
            fails++;
            $display("FAIL done_in_issue: got cyc %0d data %0d err %b v %b expected cyc 6 data %0d err 0 v 0100",
                     rq[0].c - c0, rq[0].data, rq[0].err, rq[0].v, prod(2));
        end
        m_last = 2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got time %0t expected finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0; opb[i] = '0;
        end
        test_reset();
        test_single_job();
        test_round_robin();
        test_priority_after();
        test_timeout();
        test_reset_mid();
        test_done_ignored();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
